// File: rtl/serial_mag_comp.sv
// Two-bit-per-cycle serial magnitude comparator, MSB slice first, driving an external slice comparator.
// Optional macro SERIAL_MAG_COMP_EARLY_EXIT_EN: finish on the first unequal slice instead of scanning all slices.
module serial_mag_comp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_gt,
  input  logic             slice_lt,
  input  logic             slice_eq
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_check
    $error("serial_mag_comp: WIDTH must be even and at least 2");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, a_nx, b_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             gt_nx, lt_nx, eq_nx, done_nx;
  logic             s_gt, s_lt;

  // slice_eq is implied by the priority order; an all-zero response reads as equal
  assign s_gt = slice_gt;
  assign s_lt = !slice_gt && slice_lt;
  assign busy = (state == SCAN);

`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
  logic dec_gt, dec_lt, dec_gt_nx, dec_lt_nx;
  logic res_gt, res_lt;
`endif

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    if (state == SCAN) begin
      slice_a = a_r[2*int'(idx) +: 2];
      slice_b = b_r[2*int'(idx) +: 2];
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_r;
    b_nx     = b_r;
    idx_nx   = idx;
    gt_nx    = gt;
    lt_nx    = lt;
    eq_nx    = eq;
    done_nx  = 1'b0;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
    dec_gt_nx = dec_gt;
    dec_lt_nx = dec_lt;
    res_gt    = (dec_gt || dec_lt) ? dec_gt : s_gt;
    res_lt    = (dec_gt || dec_lt) ? dec_lt : s_lt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          a_nx     = a;
          b_nx     = b;
          idx_nx   = IDX_TOP;
          gt_nx    = 1'b0;
          lt_nx    = 1'b0;
          eq_nx    = 1'b0;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
          dec_gt_nx = 1'b0;
          dec_lt_nx = 1'b0;
`endif
        end
      end
      SCAN: begin
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
        if (s_gt || s_lt || idx == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          gt_nx    = s_gt;
          lt_nx    = s_lt;
          eq_nx    = !s_gt && !s_lt;
        end else begin
          idx_nx = idx - 1'b1;
        end
`else
        // the first unequal slice is latched in dec_*; later slices cannot override it
        if (idx == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          gt_nx    = res_gt;
          lt_nx    = res_lt;
          eq_nx    = !res_gt && !res_lt;
        end else begin
          idx_nx    = idx - 1'b1;
          dec_gt_nx = res_gt;
          dec_lt_nx = res_lt;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= IDX_TOP;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      done  <= 1'b0;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      a_r   <= a_nx;
      b_r   <= b_nx;
      idx   <= idx_nx;
      gt    <= gt_nx;
      lt    <= lt_nx;
      eq    <= eq_nx;
      done  <= done_nx;
`ifndef SERIAL_MAG_COMP_EARLY_EXIT_EN
      dec_gt <= dec_gt_nx;
      dec_lt <= dec_lt_nx;
`endif
    end
  end

  logic unused_ok;
  assign unused_ok = slice_eq;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp with a behavioural slice comparator that can inject malformed responses.
module tb_serial_mag_comp;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done, gt, lt, eq;
  logic [1:0]       slice_a, slice_b;
  logic             slice_gt, slice_lt, slice_eq;
  int unsigned      mal_mode = 0;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_gt(slice_gt), .slice_lt(slice_lt), .slice_eq(slice_eq)
  );

  always #5 clk = ~clk;

  // mode 1: gt and lt both high; mode 2: all lines low
  always_comb begin
    slice_gt = slice_a > slice_b;
    slice_lt = slice_a < slice_b;
    slice_eq = slice_a == slice_b;
    if (mal_mode == 1) begin
      slice_gt = 1'b1;
      slice_lt = 1'b1;
      slice_eq = 1'b0;
    end else if (mal_mode == 2) begin
      slice_gt = 1'b0;
      slice_lt = 1'b0;
      slice_eq = 1'b0;
    end
  end

  typedef struct {
    logic [2:0]  res;   // {gt, lt, eq}
    int unsigned lat;
    int unsigned c0;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input int unsigned mode);
    exp_t        e;
    logic [1:0]  sa, sb_;
    logic [2:0]  r;
    bit          decided = 0;
    int unsigned examined = 0;
    e.res = 3'b001;
    for (int i = N - 1; i >= 0; i--) begin
      sa = av[2*i +: 2];
      sb_ = bv[2*i +: 2];
      if (mode == 1)      r = 3'b100;
      else if (mode == 2) r = 3'b001;
      else if (sa > sb_)  r = 3'b100;
      else if (sa < sb_)  r = 3'b010;
      else                r = 3'b001;
      examined++;
      if (r != 3'b001 && !decided) begin
        decided = 1;
        e.res = r;
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
        break;
`endif
      end
    end
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    e.lat = examined;
`else
    e.lat = N;
`endif
    e.c0 = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard consumer
  always @(posedge clk) begin
    #1;
    if (done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result_gt_lt_eq", {29'd0, gt, lt, eq}, {29'd0, e.res});
        check("latency", cyc - e.c0, e.lat);
        check("busy_after_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic run(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input int unsigned mode, input bit ign, input bit rst_abort);
    exp_t e;
    bit   seen = 0;
    @(negedge clk);
    mal_mode = mode;
    start = 1'b1;
    a = av;
    b = bv;
    e = model(av, bv, mode);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.c0 = cyc;
    sb.push_back(e);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("result_cleared", {29'd0, gt, lt, eq}, 32'd0);
    for (int k = 1; k <= int'(N) + 2; k++) begin
      if (k <= int'(e.lat)) begin
        check("slice_a", {30'd0, slice_a}, {30'd0, av[2*(int'(N)-k) +: 2]});
        check("slice_b", {30'd0, slice_b}, {30'd0, bv[2*(int'(N)-k) +: 2]});
      end
      if (ign && k == 2) begin
        start = 1'b1;
        a = ~av;
        b = ~bv;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rst_abort && k == 2) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {26'd0, busy, done, gt, lt, eq, slice_a}, 32'd0);
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned d0;
    #12;
    check("reset_state", {25'd0, busy, done, gt, lt, eq, slice_a, slice_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", {25'd0, busy, done, gt, lt, eq, slice_a, slice_b}, 32'd0);

    run(8'hB4, 8'h74, 0, 0, 0);
    run(8'h12, 8'h13, 0, 0, 0);
    run(8'hA5, 8'hA5, 0, 0, 0);
    run(8'h00, 8'hFF, 0, 0, 0);
    run(8'hFF, 8'hFE, 0, 0, 0);

    d0 = n_done;
    run(8'h12, 8'h13, 0, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    check("single_done_on_ignored_start", n_done - d0, 32'd1);
    check("held_lt", {29'd0, gt, lt, eq}, 32'b010);

    d0 = n_done;
    run(8'h12, 8'h13, 0, 0, 1);
    check("no_done_after_abort", n_done - d0, 32'd0);
    run(8'hFF, 8'h00, 0, 0, 0);

    run(8'h33, 8'h33, 1, 0, 0);
    run(8'h00, 8'hFF, 2, 0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1)) : WIDTH'($urandom);
      run(ra, rb, 0, 0, 0);
    end

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
